// File: rtl/univ_ff_bank.sv
// univ_ff_bank: WIDTH independent flip-flops sharing one run-time mode (SR/JK/D/T).
// Tracks S=R=1 inputs in SR mode with sticky per-bit flags and a saturating event counter.

// One storage bit. Computes its own next state and reports an illegal S=R=1 input.
module univ_ff_lane #(
    parameter int   SR_POLICY = 0,
    parameter logic RST_BIT   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       illegal
);
    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;

    logic nxt;
    logic sr_both;

    // What S=R=1 resolves to; any policy other than 1 or 2 is treated as hold
    assign sr_both = (SR_POLICY == 1) ? 1'b1 :
                     (SR_POLICY == 2) ? 1'b0 : q;

    // Only an enabled SR-mode bit with both inputs high counts as illegal
    assign illegal = en && (mode == MODE_SR) && a && b;

    // Next-state selection for the current mode
    always_comb begin
        nxt = q;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = sr_both;
                    default: nxt = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            MODE_D:  nxt = a;
            default: nxt = a ? ~q : q;
        endcase
    end

    // State register: reset wins over enable
    always_ff @(posedge clk) begin
        if (!rst_n)  q <= RST_BIT;
        else if (en) q <= nxt;
    end
endmodule

module univ_ff_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SR_POLICY = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] err_flag,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] illegal;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        univ_ff_lane #(
            .SR_POLICY (SR_POLICY),
            .RST_BIT   (RESET_VAL[i])
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .mode    (mode),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .illegal (illegal[i])
        );
    end

    assign qb = ~q;

    // Error bookkeeping: clear beats set/increment; one count per cycle however many bits are bad
    always_ff @(posedge clk) begin
        if (!rst_n || err_clr) begin
            err_flag <= '0;
            err_cnt  <= '0;
        end else begin
            err_flag <= err_flag | illegal;
            if ((|illegal) && (err_cnt != CNT_MAX))
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_univ_ff_bank.sv
// Directed bench for univ_ff_bank. Four instances share one stimulus stream:
// defaults, SR_POLICY=1 with RESET_VAL=1001, SR_POLICY=2, and CNT_W=2.
module tb_univ_ff_bank;
    logic       clk = 1'b0;
    logic       rst_n, en, err_clr;
    logic [1:0] mode;
    logic [3:0] a, b;

    logic [3:0] q_d, qb_d, fl_d;  logic [7:0] cnt_d;
    logic [3:0] q_1, qb_1, fl_1;  logic [7:0] cnt_1;
    logic [3:0] q_2, qb_2, fl_2;  logic [7:0] cnt_2;
    logic [3:0] q_c, qb_c, fl_c;  logic [1:0] cnt_c;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    univ_ff_bank u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q_d), .qb(qb_d), .err_flag(fl_d), .err_cnt(cnt_d));

    univ_ff_bank #(.RESET_VAL(4'b1001), .SR_POLICY(1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q_1), .qb(qb_1), .err_flag(fl_1), .err_cnt(cnt_1));

    univ_ff_bank #(.SR_POLICY(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q_2), .qb(qb_2), .err_flag(fl_2), .err_cnt(cnt_2));

    univ_ff_bank #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q_c), .qb(qb_c), .err_flag(fl_c), .err_cnt(cnt_c));

    // Advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; err_clr = 1'b0; mode = 2'b00; a = 4'b1111; b = 4'b1111;
        step(); step();
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL reset_q got %b exp 0000", q_d); end
        n_chk++; if (qb_d !== 4'b1111) begin n_fail++; $display("FAIL reset_qb got %b exp 1111", qb_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL reset_flag got %b exp 0000", fl_d); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt_d); end
        n_chk++; if (q_1 !== 4'b1001) begin n_fail++; $display("FAIL reset_val_q got %b exp 1001", q_1); end
        n_chk++; if (qb_1 !== 4'b0110) begin n_fail++; $display("FAIL reset_val_qb got %b exp 0110", qb_1); end
    endtask

    task automatic test_sr();
        rst_n = 1'b1; en = 1'b1; mode = 2'b00;
        a = 4'b0101; b = 4'b0000; step();
        n_chk++; if (q_d !== 4'b0101) begin n_fail++; $display("FAIL sr_set got %b exp 0101", q_d); end
        n_chk++; if (q_1 !== 4'b1101) begin n_fail++; $display("FAIL sr_set_p1 got %b exp 1101", q_1); end
        a = 4'b0000; b = 4'b0001; step();
        n_chk++; if (q_d !== 4'b0100) begin n_fail++; $display("FAIL sr_reset got %b exp 0100", q_d); end
        n_chk++; if (qb_d !== 4'b1011) begin n_fail++; $display("FAIL sr_reset_qb got %b exp 1011", qb_d); end
        a = 4'b0000; b = 4'b0000; step();
        n_chk++; if (q_d !== 4'b0100) begin n_fail++; $display("FAIL sr_hold got %b exp 0100", q_d); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL sr_cnt got %0d exp 0", cnt_d); end
    endtask

    task automatic test_sr_illegal();
        a = 4'b1000; b = 4'b1000;
        step();
        n_chk++; if (cnt_d !== 8'd1) begin n_fail++; $display("FAIL ill_cnt1 got %0d exp 1", cnt_d); end
        step(); step();
        n_chk++; if (q_d !== 4'b0100) begin n_fail++; $display("FAIL ill_hold_q got %b exp 0100", q_d); end
        n_chk++; if (fl_d !== 4'b1000) begin n_fail++; $display("FAIL ill_flag got %b exp 1000", fl_d); end
        n_chk++; if (cnt_d !== 8'd3) begin n_fail++; $display("FAIL ill_cnt3 got %0d exp 3", cnt_d); end
        n_chk++; if (q_1 !== 4'b1100) begin n_fail++; $display("FAIL ill_force1_q got %b exp 1100", q_1); end
        n_chk++; if (q_2 !== 4'b0100) begin n_fail++; $display("FAIL ill_force0_q got %b exp 0100", q_2); end
        n_chk++; if (fl_2 !== 4'b1000) begin n_fail++; $display("FAIL ill_flag_p2 got %b exp 1000", fl_2); end
        // two bad bits in one cycle still count once
        a = 4'b0011; b = 4'b0011; step();
        n_chk++; if (cnt_d !== 8'd4) begin n_fail++; $display("FAIL ill_multi_cnt got %0d exp 4", cnt_d); end
        n_chk++; if (fl_d !== 4'b1011) begin n_fail++; $display("FAIL ill_multi_flag got %b exp 1011", fl_d); end
        n_chk++; if (q_d !== 4'b0100) begin n_fail++; $display("FAIL ill_multi_hold got %b exp 0100", q_d); end
        n_chk++; if (q_1 !== 4'b1111) begin n_fail++; $display("FAIL ill_multi_p1 got %b exp 1111", q_1); end
        n_chk++; if (q_2 !== 4'b0100) begin n_fail++; $display("FAIL ill_multi_p2 got %b exp 0100", q_2); end
        n_chk++; if (cnt_c !== 2'd3) begin n_fail++; $display("FAIL ill_sat_c2 got %0d exp 3", cnt_c); end
    endtask

    task automatic test_jk_t();
        // zero the bank through D mode while clearing errors; q still updates on the clear edge
        mode = 2'b10; a = 4'b0000; b = 4'b0000; err_clr = 1'b1; step();
        err_clr = 1'b0;
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL clr_q_update got %b exp 0000", q_d); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got %0d exp 0", cnt_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL clr_flag got %b exp 0000", fl_d); end
        mode = 2'b01; a = 4'b1111; b = 4'b1111; step();
        n_chk++; if (q_d !== 4'b1111) begin n_fail++; $display("FAIL jk_tog1 got %b exp 1111", q_d); end
        step();
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL jk_tog2 got %b exp 0000", q_d); end
        a = 4'b1010; b = 4'b0101; step();
        n_chk++; if (q_d !== 4'b1010) begin n_fail++; $display("FAIL jk_setrst got %b exp 1010", q_d); end
        a = 4'b0000; b = 4'b1010; step();
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL jk_rst got %b exp 0000", q_d); end
        mode = 2'b11; a = 4'b0011; b = 4'b1111; step();
        n_chk++; if (q_d !== 4'b0011) begin n_fail++; $display("FAIL t_tog1 got %b exp 0011", q_d); end
        step();
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL t_tog2 got %b exp 0000", q_d); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL jk_t_cnt got %0d exp 0", cnt_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL jk_t_flag got %b exp 0000", fl_d); end
    endtask

    task automatic test_d_enable();
        mode = 2'b10; a = 4'b1010; b = 4'b1111; step();
        n_chk++; if (q_d !== 4'b1010) begin n_fail++; $display("FAIL d_load got %b exp 1010", q_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL d_flag got %b exp 0000", fl_d); end
        en = 1'b0; a = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            step();
            n_chk++; if (q_d !== 4'b1010) begin n_fail++; $display("FAIL en0_hold[%0d] got %b exp 1010", k, q_d); end
        end
        // illegal-looking SR input while disabled must not register
        mode = 2'b00; a = 4'b1111; b = 4'b1111; step();
        n_chk++; if (q_d !== 4'b1010) begin n_fail++; $display("FAIL en0_sr_q got %b exp 1010", q_d); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL en0_sr_cnt got %0d exp 0", cnt_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL en0_sr_flag got %b exp 0000", fl_d); end
    endtask

    task automatic test_sat_clear();
        en = 1'b1; mode = 2'b00; a = 4'b1000; b = 4'b1000;
        for (int k = 0; k < 5; k++) step();
        n_chk++; if (cnt_c !== 2'd3) begin n_fail++; $display("FAIL sat_c2 got %0d exp 3", cnt_c); end
        n_chk++; if (cnt_d !== 8'd5) begin n_fail++; $display("FAIL sat_def got %0d exp 5", cnt_d); end
        n_chk++; if (q_d !== 4'b1010) begin n_fail++; $display("FAIL sat_q got %b exp 1010", q_d); end
        err_clr = 1'b1; step();
        err_clr = 1'b0;
        n_chk++; if (cnt_c !== 2'd0) begin n_fail++; $display("FAIL clr_ill_cnt got %0d exp 0", cnt_c); end
        n_chk++; if (fl_c !== 4'b0000) begin n_fail++; $display("FAIL clr_ill_flag got %b exp 0000", fl_c); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL clr_ill_def got %0d exp 0", cnt_d); end
    endtask

    task automatic test_reset_mid();
        mode = 2'b11; a = 4'b1111; b = 4'b0000; step();
        n_chk++; if (q_d !== 4'b0101) begin n_fail++; $display("FAIL mid_tog got %b exp 0101", q_d); end
        rst_n = 1'b0; mode = 2'b00; a = 4'b1111; b = 4'b1111; step();
        n_chk++; if (q_d !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_q got %b exp 0000", q_d); end
        n_chk++; if (q_1 !== 4'b1001) begin n_fail++; $display("FAIL mid_rst_p1 got %b exp 1001", q_1); end
        n_chk++; if (cnt_d !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d exp 0", cnt_d); end
        n_chk++; if (fl_d !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_flag got %b exp 0000", fl_d); end
        rst_n = 1'b1; mode = 2'b11; a = 4'b1111; b = 4'b0000; step();
        n_chk++; if (q_d !== 4'b1111) begin n_fail++; $display("FAIL mid_resume got %b exp 1111", q_d); end
        n_chk++; if (q_1 !== 4'b0110) begin n_fail++; $display("FAIL mid_resume_p1 got %b exp 0110", q_1); end
    endtask

    initial begin
        test_reset();
        test_sr();
        test_sr_illegal();
        test_jk_t();
        test_d_enable();
        test_sat_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
